// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, field widths
// and the core-facing request/response bundles.
package data_mem_ctrl_pkg;

  localparam int unsigned data_w = 32;
  localparam int unsigned addr_w = 32;
  localparam int unsigned cnt_w  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              wen;
    logic [addr_w-1:0] addr;
    logic [data_w-1:0] wdata;
  } mem_in_s;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [data_w-1:0] rdata;
  } mem_out_s;

endpackage

// File: rtl/data_mem_ctrl_dmem_array.sv
// Word-addressed storage with synchronous write and combinational read.
// Deliberately has no reset so contents survive a controller reset.
module dmem_array
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_w-1:0]       wdata_i,
  output logic [data_w-1:0]       rdata_o
);

  logic [data_w-1:0] mem_q [2**addr_width_p];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-outstanding data-memory controller: accepts one request in IDLE,
// waits latency_p cycles, then presents a held response until consumed.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int unsigned addr_width_p = 10,
  parameter int unsigned latency_p    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  input  logic              req_wen_i,
  input  logic [addr_w-1:0] req_addr_i,
  input  logic [data_w-1:0] req_wdata_i,
  output logic              req_yumi_o,
  output logic              resp_valid_o,
  output logic [data_w-1:0] resp_rdata_o,
  output logic              resp_err_o,
  input  logic              resp_yumi_i
);

  mem_in_s           req;
  mem_out_s          resp_q, resp_d;
  state_e            state_q, state_d;
  logic [cnt_w-1:0]  cnt_q, cnt_d;
  logic              pend_err_q, pend_err_d;
  logic [data_w-1:0] pend_rdata_q, pend_rdata_d;
  logic              accept;
  logic              addr_bad;
  logic              arr_we;
  logic [data_w-1:0] arr_rdata;

  assign req = '{valid: req_valid_i, wen: req_wen_i, addr: req_addr_i, wdata: req_wdata_i};

  // Upper bits above the word index must be zero; shift form stays legal for any width.
  assign addr_bad = (req.addr[1:0] != 2'b00) ||
                    ((req.addr >> (addr_width_p + 2)) != '0);

  // Gated by reset so nothing is accepted or written while reset is held.
  assign accept = reset && (state_q == IDLE) && req.valid;
  assign arr_we = accept && req.wen && !addr_bad;

  dmem_array #(
    .addr_width_p(addr_width_p)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (req.addr[addr_width_p+1:2]),
    .wdata_i (req.wdata),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_err_d   = pend_err_q;
    pend_rdata_d = pend_rdata_q;
    resp_d       = resp_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = BUSY;
          cnt_d        = cnt_w'(latency_p - 1);
          pend_err_d   = addr_bad;
          pend_rdata_d = (addr_bad || req.wen) ? '0 : arr_rdata;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          resp_d  = '{valid: 1'b1, err: pend_err_q, rdata: pend_rdata_q};
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_yumi_i) begin
          state_d      = IDLE;
          resp_d       = '0;
          pend_err_d   = 1'b0;
          pend_rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        resp_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_err_q   <= 1'b0;
      pend_rdata_q <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_err_q   <= pend_err_d;
      pend_rdata_q <= pend_rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign req_yumi_o   = accept;
  assign resp_valid_o = resp_q.valid;
  assign resp_rdata_o = resp_q.rdata;
  assign resp_err_o   = resp_q.err;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance at latency 2, one at latency 1,
// sharing stimulus; sel chooses which instance is driven and observed.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        req_valid, req_wen, resp_yumi;
  logic [31:0] req_addr, req_wdata;

  logic        d2_yumi, d2_valid, d2_err;
  logic [31:0] d2_rdata;
  logic        d1_yumi, d1_valid, d1_err;
  logic [31:0] d1_rdata;

  logic        obs_yumi, obs_valid, obs_err;
  logic [31:0] obs_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign obs_yumi  = sel ? d1_yumi  : d2_yumi;
  assign obs_valid = sel ? d1_valid : d2_valid;
  assign obs_err   = sel ? d1_err   : d2_err;
  assign obs_rdata = sel ? d1_rdata : d2_rdata;

  data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_dut2 (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid && !sel),
    .req_wen_i    (req_wen),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_yumi_o   (d2_yumi),
    .resp_valid_o (d2_valid),
    .resp_rdata_o (d2_rdata),
    .resp_err_o   (d2_err),
    .resp_yumi_i  (resp_yumi && !sel)
  );

  data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) u_dut1 (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid && sel),
    .req_wen_i    (req_wen),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_yumi_o   (d1_yumi),
    .resp_valid_o (d1_valid),
    .resp_rdata_o (d1_rdata),
    .resp_err_o   (d1_err),
    .resp_yumi_i  (resp_yumi && sel)
  );

  // Issue one request, return the response and the cycles from acceptance
  // to resp_valid (lat = -1 when not accepted or no response came).
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; resp_yumi = 1'b0;
    lat = -1; rdata = 32'hx; err = 1'bx;
    @(negedge clk);
    if (obs_yumi !== 1'b1) begin
      req_valid = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (obs_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    if (lat < 0) begin
      @(posedge clk); #1;
      return;
    end
    rdata = obs_rdata; err = obs_err;
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    req_valid = 1'b1;
    #2;
    tests++;
    if (d2_yumi !== 1'b0 || d2_valid !== 1'b0 || d2_rdata !== 32'h0 || d2_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs_lat2: yumi=%b valid=%b rdata=%h err=%b, expected all 0",
               d2_yumi, d2_valid, d2_rdata, d2_err);
    end
    @(posedge clk); #1;
    tests++;
    if (d1_yumi !== 1'b0 || d1_valid !== 1'b0 || d1_rdata !== 32'h0 || d1_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs_lat1: yumi=%b valid=%b rdata=%h err=%b, expected all 0",
               d1_yumi, d1_valid, d1_rdata, d1_err);
    end
    req_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_req(1'b1, 32'h0, 32'h12345678, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL wr_0x0: rdata=%h err=%b lat=%0d, expected 0 0 3", rd, er, lat);
    end
    do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL wr_0x10: rdata=%h err=%b lat=%0d, expected 0 0 3", rd, er, lat);
    end
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL rd_0x10: rdata=%h err=%b lat=%0d, expected deadbeef 0 3", rd, er, lat);
    end
    do_req(1'b1, 32'hFFC, 32'hCAFEF00D, rd, er, lat);
    do_req(1'b0, 32'hFFC, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL rd_top_word: rdata=%h err=%b lat=%0d, expected cafef00d 0 3", rd, er, lat);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_req(1'b0, 32'h13, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
      fails++;
      $display("FAIL rd_misaligned: rdata=%h err=%b lat=%0d, expected 0 1 3", rd, er, lat);
    end
    do_req(1'b1, 32'h11, 32'hFFFFFFFF, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
      fails++;
      $display("FAIL wr_misaligned: rdata=%h err=%b lat=%0d, expected 0 1 3", rd, er, lat);
    end
    do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      fails++;
      $display("FAIL rd_after_misaligned: rdata=%h err=%b, expected deadbeef 0", rd, er);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_req(1'b1, 32'h1000, 32'hAAAA5555, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1 || lat !== 3) begin
      fails++;
      $display("FAIL wr_out_of_range: rdata=%h err=%b lat=%0d, expected 0 1 3", rd, er, lat);
    end
    do_req(1'b0, 32'h0, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      fails++;
      $display("FAIL rd_after_oor: rdata=%h err=%b, expected 12345678 0", rd, er);
    end
    do_req(1'b0, 32'h8000_0010, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      fails++;
      $display("FAIL rd_out_of_range: rdata=%h err=%b, expected 0 1", rd, er);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat;
    sel = 1'b0;
    do_req(1'b1, 32'h20, 32'h0BADF00D, rd, er, lat);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h20; resp_yumi = 1'b1;
    @(negedge clk);
    tests++;
    if (obs_yumi !== 1'b1) begin
      fails++;
      $display("FAIL bp_accept: req_yumi=%b, expected 1", obs_yumi);
    end
    @(posedge clk); #1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      tests++;
      if (obs_yumi !== 1'b0 || obs_valid !== 1'b0) begin
        fails++;
        $display("FAIL bp_busy_c%0d: req_yumi=%b resp_valid=%b, expected 0 0", c, obs_yumi, obs_valid);
      end
      @(posedge clk); #1;
    end
    resp_yumi = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if (obs_valid !== 1'b1 || obs_rdata !== 32'h0BADF00D || obs_err !== 1'b0 || obs_yumi !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold_c%0d: valid=%b rdata=%h err=%b req_yumi=%b, expected 1 0badf00d 0 0",
                 c, obs_valid, obs_rdata, obs_err, obs_yumi);
      end
      @(posedge clk); #1;
    end
    resp_yumi = 1'b1;
    @(negedge clk);
    tests++;
    if (obs_yumi !== 1'b0 || obs_valid !== 1'b1) begin
      fails++;
      $display("FAIL bp_consume_cycle: req_yumi=%b valid=%b, expected 0 1", obs_yumi, obs_valid);
    end
    @(posedge clk); #1;
    resp_yumi = 1'b0;
    @(negedge clk);
    tests++;
    if (obs_yumi !== 1'b1 || obs_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_next_accept: req_yumi=%b valid=%b, expected 1 0", obs_yumi, obs_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (obs_valid === 1'b1) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (lat !== 3 || obs_rdata !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL bp_second_resp: lat=%0d rdata=%h, expected 3 0badf00d", lat, obs_rdata);
    end
    resp_yumi = 1'b1;
    @(posedge clk); #1;
    resp_yumi = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    logic saw;
    sel = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h30; req_wdata = 32'h11112222;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    tests++;
    if (d2_yumi !== 1'b0 || d2_valid !== 1'b0 || d2_rdata !== 32'h0 || d2_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_busy: yumi=%b valid=%b rdata=%h err=%b, expected all 0",
               d2_yumi, d2_valid, d2_rdata, d2_err);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    reset = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (d2_valid !== 1'b0) saw = 1'b1;
    end
    tests++;
    if (saw !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_busy_no_resp: resp_valid seen=%b, expected 0", saw);
    end
    @(posedge clk); #1;
    do_req(1'b0, 32'h30, 32'h0, rd, er, lat);
    tests++;
    if (rd !== 32'h11112222 || er !== 1'b0 || lat !== 3) begin
      fails++;
      $display("FAIL rst_write_committed: rdata=%h err=%b lat=%0d, expected 11112222 0 3", rd, er, lat);
    end
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h30;
    @(negedge clk);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if (d2_valid !== 1'b1 || d2_rdata !== 32'h11112222) begin
      fails++;
      $display("FAIL rst_resp_before: valid=%b rdata=%h, expected 1 11112222", d2_valid, d2_rdata);
    end
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (d2_valid !== 1'b0 || d2_rdata !== 32'h0 || d2_err !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_resp: valid=%b rdata=%h err=%b, expected 0 0 0", d2_valid, d2_rdata, d2_err);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (d2_valid !== 1'b0) saw = 1'b1;
    end
    tests++;
    if (saw !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_resp_no_resp: resp_valid seen=%b, expected 0", saw);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_lat1();
    logic [31:0] model [8];
    logic [31:0] rd, addr, wd, exp_rd;
    logic er, wen, bad;
    int lat, kind, idx;
    sel = 1'b1;
    for (int i = 0; i < 8; i++) begin
      model[i] = 32'hA5000000 + 32'(i * 32'h111);
      do_req(1'b1, 32'(i * 4), model[i], rd, er, lat);
      tests++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
        fails++;
        $display("FAIL lat1_preload_%0d: rdata=%h err=%b lat=%0d, expected 0 0 2", i, rd, er, lat);
      end
    end
    for (int n = 0; n < 100; n++) begin
      kind = int'($urandom_range(0, 9));
      idx  = int'($urandom_range(0, 7));
      wen  = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (kind <= 6) begin
        addr = 32'(idx * 4); bad = 1'b0;
      end else if (kind == 7) begin
        addr = 32'(idx * 4) + $urandom_range(1, 3); bad = 1'b1;
      end else if (kind == 8) begin
        addr = 32'h1000 + 32'(idx * 4); bad = 1'b1;
      end else begin
        addr = 32'h8000_0000 | 32'(idx * 4); bad = 1'b1;
      end
      exp_rd = (bad || wen) ? 32'h0 : model[idx];
      do_req(wen, addr, wd, rd, er, lat);
      tests++;
      if (rd !== exp_rd || er !== bad || lat !== 2) begin
        fails++;
        $display("FAIL lat1_rand_%0d: addr=%h wen=%b rdata=%h err=%b lat=%0d, expected %h %b 2",
                 n, addr, wen, rd, er, lat, exp_rd, bad);
      end
      if (wen && !bad) model[idx] = wd;
    end
  endtask

  initial begin
    reset = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; resp_yumi = 1'b0;
    #2 reset = 1'b0;
    test_reset();
    test_write_read();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid();
    test_random_lat1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
